uart_tx16: RTL and testbench
============================

# uart_tx16

Serial transmitter for the Hack computer's I/O path. It accepts one 16-bit word over a valid/ready handshake and sends it on a single line as two 8N1 UART frames: low byte first, each byte LSB first. It sits between the memory-mapped output register and the board's TX pin, and is the transmit end of the serial link whose receive end deserializes bytes back into 16-bit words.

## Interface
- CLKS_PER_BIT, default 217: clock cycles per bit period; legal range ≥ 2 (217 ≈ 115200 baud at 25 MHz).
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- in  input  16  word to transmit; sampled only on the accepting edge.
- in_valid  input  1  producer has a word on `in`.
- in_ready  output  1  block can accept a word; equals (state == IDLE).
- tx  output  1  serial line, registered; idle level is mark (1).
- busy  output  1  equals !in_ready.

## Operation
- Transfer occurs on a rising edge with in_valid && in_ready. At that edge the block:
  - latches `in` into a 16-bit shift register;
  - clears the bit counter and the byte index;
  - enters START.
- State machine:
  - IDLE → START on transfer.
  - START: tx = 0 for one bit period, then → DATA.
  - DATA: 8 bit periods, tx = shift[0]; shift right by 1 at the end of each period; after the 8th → STOP.
  - STOP: tx = 1 for one bit period. If byte index = 0, set it to 1 and → START. If byte index = 1, → IDLE.
- Bit period is exactly CLKS_PER_BIT cycles. The cycle counter runs 0..CLKS_PER_BIT-1 and wraps at the terminal count. Counter width is $clog2(CLKS_PER_BIT).
- The bits-in-byte counter is 3 bits, and wraps 7 → 0 on the transition out of DATA.
- `in` and `in_valid` are ignored outside IDLE, so there is no mid-word overwrite. A producer dropping in_valid without a transfer has no effect.
- Reset values: state = IDLE, tx = 1, in_ready = 1, busy = 0, all counters 0, shift register 0.
- Asserting rst_n low mid-word aborts the word immediately: tx returns to 1 asynchronously and the partial word is discarded. No transfer completes while rst_n is low.

## Timing
- tx changes only on clock edges, one edge after the decision that drives it. The start bit appears on tx at the accepting edge itself.
- One word occupies 20 × CLKS_PER_BIT cycles of line time: 2 × (start + 8 data + stop).
- in_ready rises on the edge that ends the second stop bit. The earliest next transfer is that same cycle's following edge, so the back-to-back word period is 20 × CLKS_PER_BIT + 1 cycles.
- The one-cycle gap lengthens the final stop bit of each word to CLKS_PER_BIT + 1 cycles; receivers tolerate this.
- There is no gap between the first byte's stop bit and the second byte's start bit.

## Configuration
- Macro UART_TX_INVERT_EN.
- Defined: the pin is inverted after the output register, giving tx = !line.
  - Idle and reset level becomes 0, start bit 1, data bits inverted.
  - Used with level shifters that lack an inverter.
  - in_ready and busy are unchanged.
- Undefined: normal polarity as described above.

## Structure
- Shared package uart_pkg holds:
  - state encoding constants: IDLE, START, DATA, STOP (2 bits);
  - UART_IDLE_LEVEL = 1'b1;
  - UART_DATA_BITS = 8.
- The receive side imports the same package.
- One sub-module, uart_baud_tick:
  - parameterized by CLKS_PER_BIT;
  - inputs clk, rst_n, and `run` (held low in IDLE to restart phase);
  - output `tick`, one cycle wide at terminal count.

## Test plan
All scenarios use CLKS_PER_BIT = 4.
- **Reset:** rst_n low then released → tx = 1, in_ready = 1, busy = 0. in_valid asserted during reset produces no start bit.
- **Single word:** in = 16'hA55A, one-cycle in_valid → tx holds each bit 4 cycles in this order: 0, 0 1 0 1 1 0 1 0, 1, then 0, 1 0 1 0 0 1 0 1, 1. in_ready returns high exactly 80 cycles after the transfer edge.
- **Back-to-back:** in_valid held high with 16'h0001 then 16'hFFFF → the second start bit begins 81 cycles after the first. Both words are bit-exact.
- **Busy-time stimulus:** in changed and in_valid pulsed during DATA of word 16'h1234 → the transmitted bytes are still 0x34 then 0x12, and no extra frame appears.
- **Mid-word reset:** rst_n pulsed low at cycle 30 of a word → tx = 1 immediately and in_ready = 1 after release. The next word 16'h00C3 transmits cleanly.
- **Inverted build:** with UART_TX_INVERT_EN defined, repeat the single-word case → tx is the exact complement of the expected sequence, idle level 0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and line constants for the tx and rx ends.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
    localparam logic UART_IDLE_LEVEL = 1'b1;
    localparam int   UART_DATA_BITS  = 8;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter; tick pulses on the last cycle of each period, phase restarts while run is low.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic tick
);
    localparam int W = $clog2(CLKS_PER_BIT);
    logic [W-1:0] cnt;
    assign tick = run && cnt == W'(CLKS_PER_BIT - 1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (!run || tick) ? '0 : cnt + 1'b1;
    end
endmodule

// File: rtl/uart_tx16.sv
// uart_tx16: sends a 16-bit word as two 8N1 frames, low byte first, LSB first.
// Define UART_TX_INVERT_EN to invert the tx pin after the output register.
module uart_tx16
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 217
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] in,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        tx,
    output logic        busy
);
    uart_state_t state, state_n;
    logic [15:0] shift, shift_n;
    logic [2:0]  bit_cnt, bit_n;
    logic        byte_idx, byte_n;
    logic        line, line_n;
    logic        tick;

    uart_baud_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .run  (state != IDLE),
        .tick (tick)
    );

    assign in_ready = state == IDLE;
    assign busy     = !in_ready;

    always_comb begin
        state_n = state;
        shift_n = shift;
        bit_n   = bit_cnt;
        byte_n  = byte_idx;
        case (state)
            IDLE: if (in_valid) begin
                state_n = START;
                shift_n = in;
                bit_n   = '0;
                byte_n  = 1'b0;
            end
            START: if (tick) state_n = DATA;
            DATA: if (tick) begin
                shift_n = shift >> 1;
                bit_n   = bit_cnt + 3'd1;
                state_n = bit_cnt == 3'(UART_DATA_BITS - 1) ? STOP : DATA;
            end
            STOP: if (tick) begin
                byte_n  = 1'b1;
                state_n = byte_idx ? IDLE : START;
            end
        endcase
        // line reflects the next state so tx moves on the deciding edge
        line_n = state_n == START ? 1'b0 : state_n == DATA ? shift_n[0] : UART_IDLE_LEVEL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            shift    <= '0;
            bit_cnt  <= '0;
            byte_idx <= 1'b0;
            line     <= UART_IDLE_LEVEL;
        end else begin
            state    <= state_n;
            shift    <= shift_n;
            bit_cnt  <= bit_n;
            byte_idx <= byte_n;
            line     <= line_n;
        end
    end

`ifdef UART_TX_INVERT_EN
    assign tx = !line;
`else
    assign tx = line;
`endif
endmodule

// File: tb/tb_uart_tx16.sv
// tb_uart_tx16: scoreboard bench for uart_tx16 at CLKS_PER_BIT = 4; honours UART_TX_INVERT_EN.
module tb_uart_tx16;
    localparam int CPB = 4;
`ifdef UART_TX_INVERT_EN
    localparam logic POL = 1'b1;
`else
    localparam logic POL = 1'b0;
`endif
    localparam logic IDLE_TX = 1'b1 ^ POL;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready, tx, busy;
    logic        exp_q[$];
    int          vectors = 0;
    int          errors = 0;

    uart_tx16 #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic push_word(input logic [15:0] w);
        for (int b = 0; b < 2; b++) begin
            exp_q.push_back(1'b0);
            for (int i = 0; i < 8; i++) exp_q.push_back(w[8*b+i]);
            exp_q.push_back(1'b1);
        end
    endtask

    // Called at the negedge just after the accepting edge; samples n cycles of line time.
    task automatic check_word(input string name, input int n);
        logic cur = 1'b1;
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(negedge clk);
            if (i % CPB == 0) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL %s cyc %0d: scoreboard empty", name, i);
                end else cur = exp_q.pop_front();
            end
            vectors++;
            if ({tx, in_ready, busy} !== {cur ^ POL, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL %s cyc %0d: tx/rdy/busy=%b%b%b exp %b01", name, i, tx, in_ready, busy, cur ^ POL);
            end
        end
    endtask

    task automatic check_idle(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            vectors++;
            if ({tx, in_ready, busy} !== {IDLE_TX, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL %s idle %0d: tx/rdy/busy=%b%b%b exp %b10", name, i, tx, in_ready, busy, IDLE_TX);
            end
        end
    endtask

    task automatic start_word(input logic [15:0] w);
        @(negedge clk);
        in = w;
        in_valid = 1'b1;
        push_word(w);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        in_valid = 1'b1;
        in = 16'h0000;
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({tx, in_ready, busy} !== {IDLE_TX, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL reset_hold: tx/rdy/busy=%b%b%b exp %b10", tx, in_ready, busy, IDLE_TX);
            end
        end
        in_valid = 1'b0;
        rst_n = 1'b1;
        check_idle("reset_release", 3);
    endtask

    task automatic test_single;
        start_word(16'hA55A);
        check_word("single", 20 * CPB);
        check_idle("single_end", 2);
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        in = 16'h0001;
        in_valid = 1'b1;
        push_word(16'h0001);
        push_word(16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        in = 16'hFFFF;
        check_word("b2b_w0", 20 * CPB);
        @(negedge clk);
        vectors++;
        if ({tx, in_ready} !== {IDLE_TX, 1'b1}) begin
            errors++;
            $display("FAIL b2b_gap: tx/rdy=%b%b exp %b1", tx, in_ready, IDLE_TX);
        end
        @(negedge clk);
        in_valid = 1'b0;
        check_word("b2b_w1", 20 * CPB);
        check_idle("b2b_end", 2);
    endtask

    task automatic test_busy_stimulus;
        start_word(16'h1234);
        fork
            check_word("busy_stim", 20 * CPB);
            begin
                repeat (20) @(negedge clk);
                in = 16'hFFFF;
                in_valid = 1'b1;
                repeat (4) @(negedge clk);
                in_valid = 1'b0;
                in = 16'h0000;
            end
        join
        check_idle("busy_no_extra", 3 * CPB);
    endtask

    task automatic test_mid_reset;
        start_word(16'h0F0F);
        check_word("midrst_pre", 31);
        rst_n = 1'b0;
        in_valid = 1'b1;
        #1;
        vectors++;
        if ({tx, in_ready} !== {IDLE_TX, 1'b1}) begin
            errors++;
            $display("FAIL midrst_async: tx/rdy=%b%b exp %b1", tx, in_ready, IDLE_TX);
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;
        check_idle("midrst_release", 2);
        start_word(16'h00C3);
        check_word("midrst_next", 20 * CPB);
        check_idle("midrst_end", 2);
    endtask

    initial begin
        test_reset;
        test_single;
        test_back_to_back;
        test_busy_stimulus;
        test_mid_reset;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: %0d bits exp 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
